// File: rtl/bq_capture_pkg.sv
// Shared types and constants for the capture sequencer and its gate lanes.
package bq_capture_pkg;

  localparam int CNTBITS_DEF = 16;
  localparam int DWIDTH_DEF  = 128;

  // Wide enough for any practical stream width; lanes slice what they need.
  localparam int                     ZERO_FILL_W = 1024;
  localparam logic [ZERO_FILL_W-1:0] ZERO_FILL   = '0;

  // Encoding order matters: the top skips forward through zero-length states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    GATE = 3'd2,
    POST = 3'd3,
    RST  = 3'd4
  } bq_state_e;

endpackage

// File: rtl/bq_gate_lane.sv
// One ADC channel: registered pass/zero mux, data visible one cycle after the sampling edge.
module bq_gate_lane
  import bq_capture_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0] data_o
);

  logic [DWIDTH-1:0] data_q;
  logic [DWIDTH-1:0] data_d;

  assign data_d = en_i ? data_i : ZERO_FILL[DWIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bq_capture_sequencer.sv
// Capture strobe -> ADC gate window -> settle -> biquad reset pulse, with NCHAN gated streams.
module bq_capture_sequencer
  import bq_capture_pkg::*;
#(
  parameter int NCHAN   = 2,
  parameter int CNTBITS = CNTBITS_DEF,
  parameter int DWIDTH  = DWIDTH_DEF
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    capture_i,
  input  logic [CNTBITS-1:0]      pre_delay_i,
  input  logic [CNTBITS-1:0]      gate_len_i,
  input  logic [CNTBITS-1:0]      post_delay_i,
  input  logic [CNTBITS-1:0]      rst_len_i,
  input  logic [NCHAN*DWIDTH-1:0] adc_tdata,
  input  logic [NCHAN-1:0]        adc_tvalid,
  output logic [NCHAN-1:0]        adc_tready,
  output logic [NCHAN*DWIDTH-1:0] gate_tdata,
  output logic [NCHAN-1:0]        gate_tvalid,
  input  logic [NCHAN-1:0]        gate_tready,
  output logic                    bq_rst_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    missed_o
);

  bq_state_e          state_q, state_d;
  logic [CNTBITS-1:0] cnt_q, cnt_d;
  logic [CNTBITS-1:0] pre_q, pre_d;
  logic [CNTBITS-1:0] gate_q, gate_d;
  logic [CNTBITS-1:0] post_q, post_d;
  logic [CNTBITS-1:0] rstl_q, rstl_d;
  logic               busy_q, bq_rst_q, done_q, missed_q;
  logic               done_d, missed_d;

  logic               seek;
  bq_state_e          seek_from;
  logic [CNTBITS-1:0] len_pre, len_gate, len_post, len_rst;
  logic               gate_en;

  // Streams are free-running; handshake inputs carry no information here.
  logic unused_handshake;
  assign unused_handshake = &{1'b0, adc_tvalid, gate_tready};

  assign adc_tready  = '1;
  assign gate_tvalid = '1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    gate_d    = gate_q;
    post_d    = post_q;
    rstl_d    = rstl_q;
    done_d    = 1'b0;
    missed_d  = capture_i && (state_q != IDLE);
    seek      = 1'b0;
    seek_from = PRE;
    len_pre   = pre_q;
    len_gate  = gate_q;
    len_post  = post_q;
    len_rst   = rstl_q;

    case (state_q)
      IDLE: begin
        if (capture_i) begin
          pre_d     = pre_delay_i;
          gate_d    = gate_len_i;
          post_d    = post_delay_i;
          rstl_d    = rst_len_i;
          // The first state is chosen from the live inputs, since the latch only lands at this edge.
          len_pre   = pre_delay_i;
          len_gate  = gate_len_i;
          len_post  = post_delay_i;
          len_rst   = rst_len_i;
          seek      = 1'b1;
          seek_from = PRE;
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          seek      = 1'b1;
          seek_from = GATE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GATE: begin
        if (cnt_q == '0) begin
          seek      = 1'b1;
          seek_from = POST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      POST: begin
        if (cnt_q == '0) begin
          seek      = 1'b1;
          seek_from = RST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Zero-length states fall through in the same edge, so no dead cycle appears.
    if (seek) begin
      if (seek_from <= PRE && len_pre != '0) begin
        state_d = PRE;
        cnt_d   = len_pre - 1'b1;
      end else if (seek_from <= GATE && len_gate != '0) begin
        state_d = GATE;
        cnt_d   = len_gate - 1'b1;
      end else if (seek_from <= POST && len_post != '0) begin
        state_d = POST;
        cnt_d   = len_post - 1'b1;
      end else if (len_rst != '0) begin
        state_d = RST;
        cnt_d   = len_rst - 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pre_q    <= '0;
      gate_q   <= '0;
      post_q   <= '0;
      rstl_q   <= '0;
      busy_q   <= 1'b0;
      bq_rst_q <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      gate_q   <= gate_d;
      post_q   <= post_d;
      rstl_q   <= rstl_d;
      busy_q   <= (state_d != IDLE);
      bq_rst_q <= (state_d == RST);
      done_q   <= done_d;
      missed_q <= missed_d;
    end
  end

  assign busy_o   = busy_q;
  assign bq_rst_o = bq_rst_q;
  assign done_o   = done_q;
  assign missed_o = missed_q;

  // A beat is passed when the edge that samples it falls inside the GATE state.
  assign gate_en = (state_q == GATE);

  for (genvar n = 0; n < NCHAN; n++) begin : g_lane
    bq_gate_lane #(
      .DWIDTH(DWIDTH)
    ) u_lane (
      .clk_i (aclk),
      .rst_ni(aresetn),
      .en_i  (gate_en),
      .data_i(adc_tdata[n*DWIDTH +: DWIDTH]),
      .data_o(gate_tdata[n*DWIDTH +: DWIDTH])
    );
  end

endmodule

// File: tb/tb_bq_capture_sequencer.sv
// Directed bench for bq_capture_sequencer: reset, timed sequences, zero lengths, missed/held triggers, abort.
module tb_bq_capture_sequencer;

  localparam int NCHAN   = 2;
  localparam int CNTBITS = 16;
  localparam int DWIDTH  = 128;
  localparam int W       = NCHAN * DWIDTH;

  logic               aclk;
  logic               aresetn;
  logic               capture_i;
  logic [CNTBITS-1:0] pre_delay_i, gate_len_i, post_delay_i, rst_len_i;
  logic [W-1:0]       adc_tdata;
  logic [NCHAN-1:0]   adc_tvalid;
  logic [NCHAN-1:0]   adc_tready;
  logic [W-1:0]       gate_tdata;
  logic [NCHAN-1:0]   gate_tvalid;
  logic [NCHAN-1:0]   gate_tready;
  logic               bq_rst_o, busy_o, done_o, missed_o;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int t0     = 0;

  bq_capture_sequencer #(
    .NCHAN  (NCHAN),
    .CNTBITS(CNTBITS),
    .DWIDTH (DWIDTH)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .capture_i   (capture_i),
    .pre_delay_i (pre_delay_i),
    .gate_len_i  (gate_len_i),
    .post_delay_i(post_delay_i),
    .rst_len_i   (rst_len_i),
    .adc_tdata   (adc_tdata),
    .adc_tvalid  (adc_tvalid),
    .adc_tready  (adc_tready),
    .gate_tdata  (gate_tdata),
    .gate_tvalid (gate_tvalid),
    .gate_tready (gate_tready),
    .bq_rst_o    (bq_rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .missed_o    (missed_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Beat sampled at edge e carries e, tagged per channel so lane swaps show up.
  function automatic logic [W-1:0] beat(int v);
    logic [W-1:0] r;
    r = '0;
    for (int n = 0; n < NCHAN; n++)
      r[n*DWIDTH +: DWIDTH] = (DWIDTH'(n + 1) << 96) | DWIDTH'(v);
    return r;
  endfunction

  task automatic step();
    @(posedge aclk);
    ecount++;
    #1;
    adc_tdata = beat(ecount + 1);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs seen just after edge T0+j for latched lengths p/g/q/r.
  task automatic chk_at(input int p, input int g, input int q, input int r, input int j,
                        input logic miss_exp);
    int s;
    s = p + g + q + r;
    chk($sformatf("busy j=%0d", j), W'(busy_o), W'(j < s));
    chk($sformatf("bq_rst j=%0d", j), W'(bq_rst_o), W'((j >= p + g + q) && (j < s)));
    chk($sformatf("done j=%0d", j), W'(done_o), W'(j == s));
    chk($sformatf("missed j=%0d", j), W'(missed_o), W'(miss_exp));
    chk($sformatf("gate j=%0d", j), gate_tdata,
        ((j >= p + 1) && (j <= p + g)) ? beat(t0 + j) : '0);
  endtask

  task automatic trigger(input int p, input int g, input int q, input int r);
    pre_delay_i  = CNTBITS'(p);
    gate_len_i   = CNTBITS'(g);
    post_delay_i = CNTBITS'(q);
    rst_len_i    = CNTBITS'(r);
    capture_i    = 1'b1;
    step();
    t0 = ecount;
  endtask

  initial begin
    aresetn      = 1'b0;
    capture_i    = 1'b1;
    pre_delay_i  = 16'd3;
    gate_len_i   = 16'd3;
    post_delay_i = 16'd3;
    rst_len_i    = 16'd3;
    adc_tdata    = beat(1);
    adc_tvalid   = '1;
    gate_tready  = '0;

    // Reset held with capture asserted
    repeat (4) step();
    chk("rst busy", W'(busy_o), '0);
    chk("rst bq_rst", W'(bq_rst_o), '0);
    chk("rst done", W'(done_o), '0);
    chk("rst missed", W'(missed_o), '0);
    chk("rst gate", gate_tdata, '0);
    chk("tready", W'(adc_tready), W'({NCHAN{1'b1}}));
    chk("tvalid", W'(gate_tvalid), W'({NCHAN{1'b1}}));

    capture_i = 1'b0;
    aresetn   = 1'b1;
    step();
    step();
    chk("post-rst busy", W'(busy_o), '0);
    chk("post-rst done", W'(done_o), '0);
    chk("post-rst gate", gate_tdata, '0);

    // Basic: gate visible j=4..7, filter reset j=9..13, done j=14
    trigger(3, 4, 2, 5);
    capture_i = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      chk_at(3, 4, 2, 5, j, 1'b0);
      step();
    end

    // Zero pre/post/rst lengths
    trigger(0, 2, 0, 0);
    capture_i = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      chk_at(0, 2, 0, 0, j, 1'b0);
      step();
    end

    // All zero: done right after T0
    trigger(0, 0, 0, 0);
    capture_i = 1'b0;
    for (int j = 0; j <= 2; j++) begin
      chk_at(0, 0, 0, 0, j, 1'b0);
      step();
    end

    // Config change after T0 and a missed trigger
    trigger(3, 4, 2, 5);
    capture_i = 1'b0;
    for (int j = 0; j <= 17; j++) begin
      chk_at(3, 4, 2, 5, j, j == 3);
      if (j == 1) begin
        pre_delay_i  = 16'd1;
        gate_len_i   = 16'd6;
        post_delay_i = 16'd0;
        rst_len_i    = 16'd2;
      end
      if (j == 2) capture_i = 1'b1;
      if (j == 3) capture_i = 1'b0;
      step();
    end

    // Held trigger, all lengths 1: period of 5 edges with one IDLE (done) cycle
    trigger(1, 1, 1, 1);
    for (int j = 0; j <= 14; j++) begin
      chk($sformatf("held busy j=%0d", j), W'(busy_o), W'((j % 5) != 4));
      chk($sformatf("held done j=%0d", j), W'(done_o), W'((j % 5) == 4));
      chk($sformatf("held bq_rst j=%0d", j), W'(bq_rst_o), W'((j % 5) == 3));
      chk($sformatf("held missed j=%0d", j), W'(missed_o), W'((j % 5) != 0));
      chk($sformatf("held gate j=%0d", j), gate_tdata, ((j % 5) == 2) ? beat(t0 + j) : '0);
      if (j == 14) capture_i = 1'b0;
      step();
    end
    chk("held stop busy", W'(busy_o), '0);
    chk("held stop missed", W'(missed_o), '0);

    // Abort during filter reset, then a clean full sequence
    trigger(1, 1, 1, 5);
    capture_i = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      chk_at(1, 1, 1, 5, j, 1'b0);
      step();
    end
    chk("abort pre bq_rst", W'(bq_rst_o), W'(1'b1));
    aresetn = 1'b0;
    step();
    chk("abort bq_rst", W'(bq_rst_o), '0);
    chk("abort busy", W'(busy_o), '0);
    chk("abort done", W'(done_o), '0);
    chk("abort gate", gate_tdata, '0);
    aresetn = 1'b1;
    step();
    chk("abort idle busy", W'(busy_o), '0);
    trigger(2, 3, 1, 2);
    capture_i = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      chk_at(2, 3, 1, 2, j, 1'b0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
